// File: rtl/bram_cmd_pkg.sv
// Shared opcodes, response bytes and FSM state encoding
// for the UART-to-BRAM command sequencer.
package bram_cmd_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK  = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h3F;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_LEN,
        S_WDATA,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_SEND,
        S_ACK
    } state_t;

endpackage

// File: rtl/bram_cmd_timeout.sv
// Inter-byte idle counter; expired holds once LIMIT idle cycles
// have elapsed since the last clear.
module bram_cmd_timeout #(
    parameter int unsigned LIMIT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    assign expired = (count == W'(LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/bram_cmd_sequencer.sv
// Parses framed read/write commands from the UART rx stream, drives the
// single-port BRAM and returns read data or an ack byte on the tx stream.
module bram_cmd_sequencer
    import bram_cmd_pkg::*;
#(
    parameter int          ADDR_W      = 12,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              err
);

    state_t            state;
    logic              is_write;
    logic [3:0]        addr_hi;
    logic [7:0]        addr_lo;
    logic [7:0]        cnt;
    logic [ADDR_W-1:0] ptr;
    logic [11:0]       frame_addr;
    logic              timed;
    logic              expired;

    assign frame_addr = {addr_hi, addr_lo};
    assign timed = (state == S_ADDR_HI) || (state == S_ADDR_LO)
                || (state == S_LEN) || (state == S_WDATA);

    bram_cmd_timeout #(
        .LIMIT(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (rx_valid || !timed),
        .en     (timed),
        .expired(expired)
    );

    // mem_addr already holds ptr on entry to RD_ISSUE, so the synchronous
    // BRAM output is ready to capture during RD_WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            is_write  <= 1'b0;
            addr_hi   <= '0;
            addr_lo   <= '0;
            cnt       <= '0;
            ptr       <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            err    <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        busy <= 1'b1;
                        if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                            is_write <= (rx_data == OP_WRITE);
                            state    <= S_ADDR_HI;
                        end else begin
                            tx_data  <= RSP_ERR;
                            tx_valid <= 1'b1;
                            err      <= 1'b1;
                            state    <= S_ACK;
                        end
                    end
                end
                S_ADDR_HI: begin
                    if (rx_valid) begin
                        addr_hi <= rx_data[3:0];
                        state   <= S_ADDR_LO;
                    end else if (expired) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end
                end
                S_ADDR_LO: begin
                    if (rx_valid) begin
                        addr_lo <= rx_data;
                        state   <= S_LEN;
                    end else if (expired) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end
                end
                S_LEN: begin
                    if (rx_valid) begin
                        cnt      <= rx_data;
                        ptr      <= frame_addr[ADDR_W-1:0];
                        mem_addr <= frame_addr[ADDR_W-1:0];
                        state    <= is_write ? S_WDATA : S_RD_ISSUE;
                    end else if (expired) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end
                end
                S_WDATA: begin
                    if (rx_valid) begin
                        mem_addr  <= ptr;
                        mem_wdata <= rx_data;
                        mem_we    <= 1'b1;
                        ptr       <= ptr + 1'b1;
                        cnt       <= cnt - 1'b1;
                        if (cnt == 8'd0) begin
                            tx_data  <= RSP_ACK;
                            tx_valid <= 1'b1;
                            state    <= S_ACK;
                        end
                    end else if (expired) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end
                end
                S_RD_ISSUE: begin
                    err      <= rx_valid;
                    mem_addr <= ptr;
                    state    <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    err      <= rx_valid;
                    tx_data  <= mem_rdata;
                    tx_valid <= 1'b1;
                    state    <= S_RD_SEND;
                end
                S_RD_SEND: begin
                    err <= rx_valid;
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        ptr      <= ptr + 1'b1;
                        mem_addr <= ptr + 1'b1;
                        cnt      <= cnt - 1'b1;
                        if (cnt == 8'd0) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_RD_ISSUE;
                        end
                    end
                end
                S_ACK: begin
                    err <= rx_valid;
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_cmd_sequencer.sv
// Scoreboard bench for bram_cmd_sequencer: stimulus pushes expected writes,
// tx bytes and err pulses; a negedge monitor pops and compares.
module tb_bram_cmd_sequencer;

    localparam int TO = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    bram_cmd_sequencer #(
        .ADDR_W     (12),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .err      (err)
    );

    // Synchronous single-port BRAM
    logic [7:0] bram [0:4095] = '{default: 8'h00};
    always @(posedge clk) begin
        if (mem_we) bram[mem_addr] <= mem_wdata;
        mem_rdata <= bram[mem_addr];
    end

    int checks = 0;
    int fails = 0;
    int seen_err = 0;
    int exp_err = 0;
    int ready_mode = 0;

    logic [7:0]  ref_mem [0:4095] = '{default: 8'h00};
    logic [7:0]  exp_tx [$];
    logic [19:0] exp_wr [$];
    logic [7:0]  e_tx;
    logic [19:0] e_wr;
    logic        err_prev = 1'b0;
    logic        stall_prev = 1'b0;
    logic [7:0]  held = 8'h00;

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // tx_ready: 0 = always high, 1 = random, 2 = held low
    initial forever begin
        @(posedge clk);
        #1;
        tx_ready = (ready_mode == 0) ? 1'b1 :
                   (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    always @(negedge clk) begin
        if (rst) begin
            err_prev   = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check(tx_valid && tx_data == held, "tx_hold",
                      int'({tx_valid, tx_data}), int'({1'b1, held}));
            if (mem_we) begin
                if (exp_wr.size() == 0) begin
                    check(1'b0, "unexpected_write", int'({mem_addr, mem_wdata}), 0);
                end else begin
                    e_wr = exp_wr.pop_front();
                    check({mem_addr, mem_wdata} == e_wr, "mem_write",
                          int'({mem_addr, mem_wdata}), int'(e_wr));
                end
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    check(1'b0, "unexpected_tx", int'(tx_data), 0);
                end else begin
                    e_tx = exp_tx.pop_front();
                    check(tx_data == e_tx, "tx_byte", int'(tx_data), int'(e_tx));
                end
            end
            if (err) begin
                seen_err++;
                check(!err_prev, "err_pulse_width", int'(err_prev), 0);
            end
            err_prev   = err;
            stall_prev = tx_valid && !tx_ready;
            held       = tx_data;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic do_write(input logic [11:0] a, input logic [3:0] junk,
                            input logic [7:0] d [$]);
        logic [11:0] p;
        p = a;
        foreach (d[i]) begin
            exp_wr.push_back({p, d[i]});
            ref_mem[p] = d[i];
            p = p + 12'd1;
        end
        exp_tx.push_back(8'h4B);
        send_byte(8'h57);
        send_byte({junk, a[11:8]});
        send_byte(a[7:0]);
        send_byte(8'(d.size() - 1));
        foreach (d[i]) send_byte(d[i]);
    endtask

    task automatic do_read(input logic [11:0] a, input logic [3:0] junk, input int len);
        for (int i = 0; i < len; i++) exp_tx.push_back(ref_mem[12'(a + 12'(i))]);
        send_byte(8'h52);
        send_byte({junk, a[11:8]});
        send_byte(a[7:0]);
        send_byte(8'(len - 1));
    endtask

    task automatic bad_op(input logic [7:0] b);
        exp_tx.push_back(8'h3F);
        exp_err++;
        send_byte(b);
    endtask

    task automatic wait_idle(input string name);
        int n;
        for (n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!busy && exp_tx.size() == 0 && exp_wr.size() == 0) break;
        end
        check(n < 3000, name, n, 3000);
        repeat (2) @(negedge clk);
        check(seen_err == exp_err, {name, "_err_count"}, seen_err, exp_err);
    endtask

    initial begin
        logic [7:0] q [$];
        logic [11:0] a;
        int r;
        int n;

        repeat (3) @(posedge clk);
        #1;
        check(tx_valid == 1'b0, "rst_tx_valid", int'(tx_valid), 0);
        check(tx_data == 8'h00, "rst_tx_data", int'(tx_data), 0);
        check(busy == 1'b0, "rst_busy", int'(busy), 0);
        check(mem_we == 1'b0 && mem_addr == 12'h000 && mem_wdata == 8'h00,
              "rst_mem", int'({mem_we, mem_addr, mem_wdata}), 0);
        check(err == 1'b0, "rst_err", int'(err), 0);
        rst = 1'b0;
        ready_mode = 0;

        do_write(12'h123, 4'h0, '{8'hAA, 8'hBB, 8'hCC});
        wait_idle("write_basic");
        do_read(12'h123, 4'h0, 3);
        wait_idle("read_back");
        check(busy == 1'b0, "busy_after_read", int'(busy), 0);

        do_write(12'hFFF, 4'h0, '{8'h11, 8'h22});
        wait_idle("write_wrap");
        do_read(12'hFFF, 4'hF, 2);
        wait_idle("read_wrap");

        bad_op(8'h00);
        wait_idle("bad_opcode");
        do_write(12'h040, 4'h3, '{8'h5A});
        wait_idle("after_bad_op");

        ready_mode = 2;
        do_read(12'h122, 4'h0, 4);
        repeat (10) @(posedge clk);
        exp_err++;
        send_byte(8'h99);
        repeat (40) @(posedge clk);
        ready_mode = 0;
        wait_idle("backpressure");

        q.delete();
        for (int i = 0; i < 256; i++) q.push_back(8'($urandom));
        ready_mode = 1;
        do_write(12'hF80, 4'h0, q);
        wait_idle("write_len256");
        do_read(12'hF80, 4'h0, 256);
        wait_idle("read_len256");

        for (int k = 0; k < 25; k++) begin
            r = $urandom_range(0, 9);
            a = ($urandom_range(0, 1) == 1) ? 12'(12'h100 + $urandom_range(0, 63))
                                            : 12'(12'hFF8 + $urandom_range(0, 15));
            if (r < 4) begin
                q.delete();
                for (int i = 0; i < $urandom_range(1, 6); i++) q.push_back(8'($urandom));
                do_write(a, 4'($urandom), q);
            end else if (r < 9) begin
                do_read(a, 4'($urandom), $urandom_range(1, 8));
            end else begin
                bad_op(8'($urandom_range(0, 8'h51)));
            end
            wait_idle("random_cmd");
        end

        ready_mode = 0;
        send_byte(8'h57);
        send_byte(8'h00);
        for (n = 1; n < 1000; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        exp_err++;
        check(n >= TO && n <= TO + 3, "timeout_cycles", n, TO + 1);
        wait_idle("timeout");

        ready_mode = 2;
        do_read(12'h123, 4'h0, 8);
        repeat (12) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check(tx_valid == 1'b0, "midrst_tx_valid", int'(tx_valid), 0);
        check(busy == 1'b0, "midrst_busy", int'(busy), 0);
        check(tx_data == 8'h00 && mem_addr == 12'h000 && mem_we == 1'b0 && err == 1'b0,
              "midrst_outputs", int'({tx_data, mem_addr, mem_we, err}), 0);
        exp_tx.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        ready_mode = 0;
        do_read(12'h123, 4'h0, 3);
        wait_idle("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
